digital_clock_param: RTL

Parametrised successor to the team's 1 Hz digital clock. It runs from a fast system clock with an internal seconds prescaler and keeps seconds, minutes and hours, with a selectable 12/24-hour display. It adds runtime time-set, run/stop, a daily alarm with acknowledge, and one-cycle tick and day-rollover strobes. It sits between the board clock and the display/bell logic.

---
 rtl/clock_pkg.sv | 34 +++
 rtl/tick_prescaler.sv | 40 ++++
 rtl/digital_clock_param.sv | 129 ++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared widths, limits, a packed time-of-day record and the 24h-to-12h display mapping
// for the parametrised digital clock.
package clock_pkg;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
  } time_t;

  // Returns {pm, hour12}; the hour 0 and hour 12 cases both display as 12.
  function automatic logic [HOUR_W:0] to_12h(input logic [HOUR_W-1:0] hour);
    logic [HOUR_W:0] res;
    if (hour == 5'd0) begin
      res = {1'b0, 5'd12};
    end else if (hour < 5'd12) begin
      res = {1'b0, hour};
    end else if (hour == 5'd12) begin
      res = {1'b1, 5'd12};
    end else begin
      res = {1'b1, hour - 5'd12};
    end
    return res;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Seconds prescaler: counts running clk cycles and pulses adv on the last cycle of each second.
// clear restarts the second from zero and takes priority over counting.
module tick_prescaler #(
  parameter int TICK_DIV = 100_000_000,
  parameter int PRESC_W  = $clog2(TICK_DIV)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic adv
);

  localparam logic [PRESC_W-1:0] LAST = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] presc_d;

  assign adv = run && (presc_q == LAST);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    presc_d = presc_q;
    if (clear) begin
      presc_d = '0;
    end else if (run) begin
      presc_d = (presc_q == LAST) ? '0 : presc_q + PRESC_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/digital_clock_param.sv
// Parametrised time-of-day clock with seconds prescaler, runtime set, run/stop, daily alarm
// and 12/24-hour display mapping.
module digital_clock_param
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000,
  parameter int PRESC_W  = $clog2(TICK_DIV)
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              run,
  input  logic              mode_12h,
  input  logic              set_valid,
  input  logic [SEC_W-1:0]  set_sec,
  input  logic [MIN_W-1:0]  set_min,
  input  logic [HOUR_W-1:0] set_hour,
  input  logic              alarm_wr,
  input  logic [HOUR_W-1:0] alarm_hour,
  input  logic [MIN_W-1:0]  alarm_min,
  input  logic              alarm_en,
  input  logic              alarm_ack,
  output logic [SEC_W-1:0]  seconds,
  output logic [MIN_W-1:0]  minutes,
  output logic [HOUR_W-1:0] hours,
  output logic              pm,
  output logic              tick_1s,
  output logic              day_tick,
  output logic              alarm,
  output logic              set_err
);

  time_t             time_q, time_d;
  logic [HOUR_W-1:0] alm_h_q, alm_h_d;
  logic [MIN_W-1:0]  alm_m_q, alm_m_d;
  logic              alarm_q, alarm_d;
  logic              tick_q, tick_d;
  logic              day_q, day_d;
  logic              err_q, err_d;

  logic              adv;
  logic              set_ok;
  logic              alm_ok;
  logic              trig;
  logic [HOUR_W:0]   disp12;

  assign set_ok = set_valid && (set_sec <= SEC_MAX) && (set_min <= MIN_MAX)
                  && (set_hour <= HOUR_MAX);
  assign alm_ok = alarm_wr && (alarm_hour <= HOUR_MAX) && (alarm_min <= MIN_MAX);

  // A valid set restarts the second, which also drops any advance due this cycle.
  tick_prescaler #(
    .TICK_DIV (TICK_DIV),
    .PRESC_W  (PRESC_W)
  ) u_presc (
    .clk   (Clk),
    .rst_n (reset),
    .run   (run),
    .clear (set_ok),
    .adv   (adv)
  );

  always_comb begin
    time_d = time_q;
    tick_d = 1'b0;
    day_d  = 1'b0;
    if (set_ok) begin
      time_d = '{hour: set_hour, min: set_min, sec: set_sec};
    end else if (adv) begin
      tick_d = 1'b1;
      if (time_q.sec == SEC_MAX) begin
        time_d.sec = '0;
        if (time_q.min == MIN_MAX) begin
          time_d.min = '0;
          if (time_q.hour == HOUR_MAX) begin
            time_d.hour = '0;
            day_d       = 1'b1;
          end else begin
            time_d.hour = time_q.hour + 5'd1;
          end
        end else begin
          time_d.min = time_q.min + 6'd1;
        end
      end else begin
        time_d.sec = time_q.sec + 6'd1;
      end
    end
  end

  // Only a genuine advance can trigger; a set landing on the alarm time stays silent.
  always_comb begin
    trig    = adv && !set_ok && alarm_en && (time_d.sec == '0)
              && (time_d.min == alm_m_q) && (time_d.hour == alm_h_q);
    alarm_d = trig || (alarm_q && !alarm_ack);
    alm_h_d = alm_ok ? alarm_hour : alm_h_q;
    alm_m_d = alm_ok ? alarm_min  : alm_m_q;
    err_d   = (set_valid && !set_ok) || (alarm_wr && !alm_ok);
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      time_q  <= '0;
      alm_h_q <= '0;
      alm_m_q <= '0;
      alarm_q <= 1'b0;
      tick_q  <= 1'b0;
      day_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      time_q  <= time_d;
      alm_h_q <= alm_h_d;
      alm_m_q <= alm_m_d;
      alarm_q <= alarm_d;
      tick_q  <= tick_d;
      day_q   <= day_d;
      err_q   <= err_d;
    end
  end

  assign disp12   = to_12h(time_q.hour);
  assign seconds  = time_q.sec;
  assign minutes  = time_q.min;
  assign hours    = mode_12h ? disp12[HOUR_W-1:0] : time_q.hour;
  assign pm       = mode_12h && disp12[HOUR_W];
  assign tick_1s  = tick_q;
  assign day_tick = day_q;
  assign alarm    = alarm_q;
  assign set_err  = err_q;

endmodule
